// File: rtl/l2_distribute_rr.sv
// l2_distribute_rr: sits between the L1/SM memory interface and NUM_BANK L2 banks.
//   Request path : one registered slot. Each request is steered to the bank chosen
//                  by an address bit field. Issue is throttled per bank by an
//                  outstanding-request limit.
//   Response path: a round-robin arbiter merges the bank responses into one
//                  registered output slot.
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   req_in_*                  upstream request (valid/ready/bits)
//   req_out_*                 per-bank requests; bank b uses bits slice [b*REQ_W +: REQ_W]
//   rsp_in_*                  per-bank responses; bank b uses bits slice [b*RSP_W +: RSP_W]
//   rsp_out_*                 merged response (valid/ready/bits)
//   idle_o                    both slots empty and every bank counter is zero
//   err_o                     sticky: a bank responded while its counter was zero
module l2_distribute_rr #(
  parameter  int NUM_BANK        = 4,
  parameter  int BANK_LSB        = 6,
  parameter  int MAX_OUTSTANDING = 8,
  parameter  int ADDR_W          = 32,
  parameter  int OP_W            = 3,
  parameter  int SIZE_W          = 3,
  parameter  int SRC_W           = 8,
  parameter  int MASK_W          = 4,
  parameter  int DATA_W          = 32,
  localparam int BANK_BITS       = (NUM_BANK == 1) ? 1 : $clog2(NUM_BANK),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  localparam int REQ_W           = 3 + OP_W + SIZE_W + SRC_W + ADDR_W + MASK_W + DATA_W,
  localparam int RSP_W           = 3 + OP_W + SIZE_W + SRC_W + ADDR_W + DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_in_valid_i,
  output logic                      req_in_ready_o,
  input  logic [REQ_W-1:0]          req_in_bits_i,
  output logic [NUM_BANK-1:0]       req_out_valid_o,
  input  logic [NUM_BANK-1:0]       req_out_ready_i,
  output logic [NUM_BANK*REQ_W-1:0] req_out_bits_o,
  input  logic [NUM_BANK-1:0]       rsp_in_valid_i,
  output logic [NUM_BANK-1:0]       rsp_in_ready_o,
  input  logic [NUM_BANK*RSP_W-1:0] rsp_in_bits_i,
  output logic                      rsp_out_valid_o,
  input  logic                      rsp_out_ready_i,
  output logic [RSP_W-1:0]          rsp_out_bits_o,
  output logic                      idle_o,
  output logic                      err_o
);

  localparam logic [CNT_W-1:0]     MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [BANK_BITS:0]   NB_EXT   = (BANK_BITS + 1)'(NUM_BANK);
  localparam int                   ADDR_LSB = MASK_W + DATA_W;

  // Registered state
  logic                 r_slot_valid;
  logic [REQ_W-1:0]     r_slot_bits;
  logic [BANK_BITS-1:0] r_slot_bank;
  logic                 r_rsp_valid;
  logic [RSP_W-1:0]     r_rsp_bits;
  logic [BANK_BITS-1:0] r_rr_ptr;
  logic [CNT_W-1:0]     r_cnt [NUM_BANK];
  logic                 r_err;

  // Combinational signals
  logic [ADDR_W-1:0]    w_in_addr;
  logic [BANK_BITS-1:0] w_in_field;
  logic [BANK_BITS-1:0] w_in_bank;
  logic                 w_head_under;
  logic                 w_drain;
  logic                 w_req_fire;
  logic                 w_rsp_free;
  logic                 w_grant;
  logic [BANK_BITS-1:0] w_grant_idx;
  logic [NUM_BANK-1:0]  w_inc;
  logic [NUM_BANK-1:0]  w_dec;
  logic                 w_cnt_zero;

  // Bank selection. The field holds fewer than 2*NUM_BANK values, so one
  // conditional subtraction is enough to wrap it modulo NUM_BANK.
  assign w_in_addr  = req_in_bits_i[ADDR_LSB +: ADDR_W];
  assign w_in_field = w_in_addr[BANK_LSB +: BANK_BITS];

  // NOTE: every signal driven from always_comb gets a default before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_in_bank = w_in_field;
    if (NUM_BANK == 1) begin
      w_in_bank = '0;
    end else if ({1'b0, w_in_field} >= NB_EXT) begin
      w_in_bank = w_in_field - NB_EXT[BANK_BITS-1:0];
    end
  end

  // Request slot. It drains only while its bank is ready and below the limit.
  // A full bank blocks the head of the queue, and this is intended.
  assign w_head_under   = r_cnt[r_slot_bank] < MAX_CNT;
  assign w_drain        = r_slot_valid && w_head_under && req_out_ready_i[r_slot_bank];
  assign req_in_ready_o = !r_slot_valid || w_drain;
  assign w_req_fire     = req_in_valid_i && req_in_ready_o;
  assign req_out_bits_o = {NUM_BANK{r_slot_bits}};

  always_comb begin
    req_out_valid_o = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      req_out_valid_o[b] = r_slot_valid && w_head_under && (r_slot_bank == BANK_BITS'(b));
    end
  end

  // Round-robin arbiter. The search starts at r_rr_ptr. Nothing is granted
  // while the output slot cannot accept a response, or while reset is asserted.
  assign w_rsp_free = !r_rsp_valid || rsp_out_ready_i;

  always_comb begin
    int v_idx;
    w_grant     = 1'b0;
    w_grant_idx = '0;
    v_idx       = 0;
    for (int i = 0; i < NUM_BANK; i++) begin
      v_idx = (int'(r_rr_ptr) + i) % NUM_BANK;
      if (!w_grant && rsp_in_valid_i[v_idx]) begin
        w_grant     = 1'b1;
        w_grant_idx = BANK_BITS'(v_idx);
      end
    end
    if (rst || !w_rsp_free) begin
      w_grant     = 1'b0;
      w_grant_idx = '0;
    end
  end

  always_comb begin
    rsp_in_ready_o = '0;
    if (w_grant) rsp_in_ready_o[w_grant_idx] = 1'b1;
  end

  // Per-bank counter events: a request leaving the slot, or a response accepted.
  always_comb begin
    w_inc      = '0;
    w_dec      = '0;
    w_cnt_zero = 1'b1;
    for (int b = 0; b < NUM_BANK; b++) begin
      w_inc[b] = w_drain && (r_slot_bank == BANK_BITS'(b));
      w_dec[b] = w_grant && (w_grant_idx == BANK_BITS'(b));
      if (r_cnt[b] != '0) w_cnt_zero = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_valid <= 1'b0;
      r_slot_bits  <= '0;
      r_slot_bank  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_bits   <= '0;
      r_rr_ptr     <= '0;
      r_err        <= 1'b0;
      // NOTE: the counter array is reset explicitly. It is live control state,
      // not a storage memory, and idle_o depends on it from the first cycle.
      for (int b = 0; b < NUM_BANK; b++) r_cnt[b] <= '0;
    end else begin
      if (w_req_fire) begin
        r_slot_valid <= 1'b1;
        r_slot_bits  <= req_in_bits_i;
        r_slot_bank  <= w_in_bank;
      end else if (w_drain) begin
        r_slot_valid <= 1'b0;
      end

      if (w_grant) begin
        r_rsp_valid <= 1'b1;
        r_rsp_bits  <= rsp_in_bits_i[int'(w_grant_idx)*RSP_W +: RSP_W];
        r_rr_ptr    <= (w_grant_idx == BANK_BITS'(NUM_BANK - 1)) ? '0 : w_grant_idx + 1'b1;
      end else if (rsp_out_ready_i) begin
        r_rsp_valid <= 1'b0;
      end

      // A response from a bank whose counter is zero has no matching request.
      // The counter saturates at zero and the error flag is set.
      for (int b = 0; b < NUM_BANK; b++) begin
        if (w_dec[b] && r_cnt[b] == '0) r_err <= 1'b1;
        if (w_inc[b] && !w_dec[b]) begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end else if (w_dec[b] && !w_inc[b] && r_cnt[b] != '0) begin
          r_cnt[b] <= r_cnt[b] - 1'b1;
        end
      end
    end
  end

  assign rsp_out_valid_o = r_rsp_valid;
  assign rsp_out_bits_o  = r_rsp_bits;
  assign idle_o          = !r_slot_valid && !r_rsp_valid && w_cnt_zero;
  assign err_o           = r_err;

endmodule

// File: tb/tb_l2_distribute_rr.sv
// tb_l2_distribute_rr: scoreboard bench for l2_distribute_rr (4 banks, limit of 2 per bank).
// The reference model holds the accepted-but-not-issued requests in a queue, the
// expected merged responses in a queue, and an in-flight count per bank. It
// predicts each cycle's handshakes from those queues and counts.
module tb_l2_distribute_rr;

  localparam int NB    = 4;
  localparam int LSB   = 6;
  localparam int MAXO  = 2;
  localparam int AW    = 32;
  localparam int OW    = 3;
  localparam int SW    = 3;
  localparam int SRCW  = 8;
  localparam int MW    = 4;
  localparam int DW    = 32;
  localparam int REQ_W = 3 + OW + SW + SRCW + AW + MW + DW;
  localparam int RSP_W = 3 + OW + SW + SRCW + AW + DW;
  localparam int A_LSB = MW + DW;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_in_valid_i;
  logic                  req_in_ready_o;
  logic [REQ_W-1:0]      req_in_bits_i;
  logic [NB-1:0]         req_out_valid_o;
  logic [NB-1:0]         req_out_ready_i;
  logic [NB*REQ_W-1:0]   req_out_bits_o;
  logic [NB-1:0]         rsp_in_valid_i;
  logic [NB-1:0]         rsp_in_ready_o;
  logic [NB*RSP_W-1:0]   rsp_in_bits_i;
  logic                  rsp_out_valid_o;
  logic                  rsp_out_ready_i;
  logic [RSP_W-1:0]      rsp_out_bits_o;
  logic                  idle_o;
  logic                  err_o;

  l2_distribute_rr #(
    .NUM_BANK(NB), .BANK_LSB(LSB), .MAX_OUTSTANDING(MAXO), .ADDR_W(AW), .OP_W(OW),
    .SIZE_W(SW), .SRC_W(SRCW), .MASK_W(MW), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_in_valid_i(req_in_valid_i), .req_in_ready_o(req_in_ready_o), .req_in_bits_i(req_in_bits_i),
    .req_out_valid_o(req_out_valid_o), .req_out_ready_i(req_out_ready_i), .req_out_bits_o(req_out_bits_o),
    .rsp_in_valid_i(rsp_in_valid_i), .rsp_in_ready_o(rsp_in_ready_o), .rsp_in_bits_i(rsp_in_bits_i),
    .rsp_out_valid_o(rsp_out_valid_o), .rsp_out_ready_i(rsp_out_ready_i), .rsp_out_bits_o(rsp_out_bits_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [REQ_W-1:0] m_req_q[$];
  logic [RSP_W-1:0] m_rsp_q[$];
  int               m_cnt [NB];
  int               m_ptr;
  bit               m_err;
  bit               req_in_fired;
  logic [NB-1:0]    rsp_fired;
  int               grant_log[$];

  function automatic int bank_of(input logic [REQ_W-1:0] bits);
    logic [AW-1:0] a;
    a = bits[A_LSB +: AW];
    return int'((a >> LSB) % NB);
  endfunction

  // Monitor: at each falling edge, compare the DUT against the model, then
  // advance the model by the handshakes that happen on the next rising edge.
  bit               mon_has, mon_in_rdy, mon_free, mon_idle;
  int               mon_hb, mon_win, mon_b;
  logic [REQ_W-1:0] mon_head;
  logic [NB-1:0]    mon_rv, mon_rr, mon_inc;

  always @(negedge clk) begin
    if (rst) begin
      m_req_q.delete();
      m_rsp_q.delete();
      foreach (m_cnt[b]) m_cnt[b] = 0;
      m_ptr        = 0;
      m_err        = 1'b0;
      req_in_fired = 1'b0;
      rsp_fired    = '0;
    end else begin
      mon_has  = m_req_q.size() > 0;
      mon_rv   = '0;
      mon_hb   = 0;
      mon_head = '0;
      if (mon_has) begin
        mon_head = m_req_q[0];
        mon_hb   = bank_of(mon_head);
        if (m_cnt[mon_hb] < MAXO) mon_rv[mon_hb] = 1'b1;
      end
      mon_in_rdy = !mon_has || (mon_rv[mon_hb] && req_out_ready_i[mon_hb]);
      check("req_out_valid", req_out_valid_o, mon_rv);
      check("req_in_ready", req_in_ready_o, mon_in_rdy);
      if (mon_rv != '0) check("req_out_bits", req_out_bits_o[mon_hb*REQ_W +: REQ_W], mon_head);
      check("rsp_out_valid", rsp_out_valid_o, m_rsp_q.size() > 0);
      if (m_rsp_q.size() > 0) check("rsp_out_bits", rsp_out_bits_o, m_rsp_q[0]);
      mon_idle = !mon_has && (m_rsp_q.size() == 0);
      foreach (m_cnt[b]) if (m_cnt[b] != 0) mon_idle = 1'b0;
      check("idle", idle_o, mon_idle);
      check("err", err_o, m_err);

      mon_free = (m_rsp_q.size() == 0) || rsp_out_ready_i;
      mon_win  = -1;
      if (mon_free) begin
        for (int i = 0; i < NB; i++) begin
          mon_b = (m_ptr + i) % NB;
          if (mon_win < 0 && rsp_in_valid_i[mon_b]) mon_win = mon_b;
        end
      end
      mon_rr = '0;
      if (mon_win >= 0) mon_rr[mon_win] = 1'b1;
      check("rsp_in_ready", rsp_in_ready_o, mon_rr);

      mon_inc = '0;
      if (mon_rv != '0 && req_out_ready_i[mon_hb]) begin
        void'(m_req_q.pop_front());
        mon_inc[mon_hb] = 1'b1;
      end
      req_in_fired = req_in_valid_i && mon_in_rdy;
      if (req_in_fired) m_req_q.push_back(req_in_bits_i);
      if (m_rsp_q.size() > 0 && rsp_out_ready_i) void'(m_rsp_q.pop_front());
      if (mon_win >= 0) begin
        m_rsp_q.push_back(rsp_in_bits_i[mon_win*RSP_W +: RSP_W]);
        m_ptr = (mon_win + 1) % NB;
        grant_log.push_back(mon_win);
      end
      for (int b = 0; b < NB; b++) begin
        if (mon_rr[b] && m_cnt[b] == 0) m_err = 1'b1;
        if (mon_inc[b] && !mon_rr[b]) m_cnt[b]++;
        else if (mon_rr[b] && !mon_inc[b] && m_cnt[b] > 0) m_cnt[b]--;
      end
      rsp_fired = mon_rr;
    end
  end

  // Stimulus helpers
  bit auto_rsp;
  int rsp_pct;

  // Each bank answers only requests it actually holds. It keeps valid high until accepted.
  task automatic rsp_update();
    for (int b = 0; b < NB; b++) begin
      if (rsp_fired[b]) rsp_in_valid_i[b] = 1'b0;
      if (auto_rsp && !rsp_in_valid_i[b] && m_cnt[b] > 0 && $urandom_range(99) < rsp_pct) begin
        rsp_in_valid_i[b] = 1'b1;
        rsp_in_bits_i[b*RSP_W +: RSP_W] = RSP_W'({$urandom, $urandom, $urandom});
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rsp_update();
  endtask

  task automatic set_req(input logic [AW-1:0] addr);
    req_in_valid_i = 1'b1;
    req_in_bits_i  = REQ_W'({$urandom, $urandom, $urandom});
    req_in_bits_i[A_LSB +: AW] = addr;
  endtask

  task automatic send_req(input logic [AW-1:0] addr);
    int n;
    set_req(addr);
    n = 0;
    do begin
      step();
      n++;
    end while (!req_in_fired && n < 50);
    check("send_req_accepted", req_in_fired, 1'b1);
  endtask

  task automatic manual_rsp(input int b);
    rsp_in_valid_i[b] = 1'b1;
    rsp_in_bits_i[b*RSP_W +: RSP_W] = RSP_W'({$urandom, $urandom, $urandom});
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_in_valid_i = 1'b0;
    rsp_in_valid_i = '0;
    auto_rsp       = 1'b0;
    @(negedge clk);
    check("rst_idle", idle_o, 1'b1);
    check("rst_err", err_o, 1'b0);
    check("rst_req_out_valid", req_out_valid_o, '0);
    check("rst_rsp_out_valid", rsp_out_valid_o, 1'b0);
    check("rst_rsp_in_ready", rsp_in_ready_o, '0);
    check("rst_rsp_out_bits", rsp_out_bits_o, '0);
    check("rst_req_out_bits", req_out_bits_o[REQ_W-1:0], '0);
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_in_valid_i  = 1'b0;
    req_out_ready_i = '1;
    rsp_out_ready_i = 1'b1;
    auto_rsp        = 1'b1;
    rsp_pct         = 100;
    rsp_update();
    while (!idle_o && n < 300) begin
      step();
      n++;
    end
    check("drain_idle", idle_o, 1'b1);
    auto_rsp = 1'b0;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b0;
    req_in_valid_i = 1'b0; req_in_bits_i = '0; req_out_ready_i = '0;
    rsp_in_valid_i = '0; rsp_in_bits_i = '0; rsp_out_ready_i = 1'b0;
    auto_rsp = 1'b0; rsp_pct = 0;
    #1;
    do_reset();

    // Each bank once: one-hot valid sequence, one cycle after each accept
    req_out_ready_i = '1;
    send_req(32'h00); send_req(32'h40); send_req(32'h80); send_req(32'hC0);
    req_in_valid_i = 1'b0;
    @(negedge clk);
    check("seq_last_bank3", req_out_valid_o, 4'b1000);
    step();
    @(negedge clk);
    check("seq_busy", idle_o, 1'b0);
    drain();

    // Bank 2 stalls: slot holds; the slot drains as soon as ready rises
    req_out_ready_i[2] = 1'b0;
    send_req(32'h80);
    set_req(32'h00);
    repeat (3) step();
    @(negedge clk);
    check("stall_in_ready", req_in_ready_o, 1'b0);
    check("stall_valid", req_out_valid_o, 4'b0100);
    step();
    req_out_ready_i[2] = 1'b1;
    @(negedge clk);
    check("stall_release_ready", req_in_ready_o, 1'b1);
    step();
    check("stall_second_accepted", req_in_fired, 1'b1);
    req_in_valid_i = 1'b0;
    drain();

    // Throttle: third request to bank 1 waits for a response
    req_out_ready_i = '1;
    rsp_out_ready_i = 1'b1;
    send_req(32'h40); send_req(32'h40); send_req(32'h40);
    req_in_valid_i = 1'b0;
    step();
    @(negedge clk);
    check("throttle_valid", req_out_valid_o, 4'b0000);
    check("throttle_in_ready", req_in_ready_o, 1'b0);
    step();
    manual_rsp(1);
    step();
    @(negedge clk);
    check("throttle_release", req_out_valid_o, 4'b0010);
    drain();

    // Round-robin order with all banks responding continuously
    do_reset();
    req_out_ready_i = '1;
    for (int k = 0; k < 2; k++) begin
      send_req(32'h00); send_req(32'h40); send_req(32'h80); send_req(32'hC0);
    end
    req_in_valid_i = 1'b0;
    step();
    grant_log.delete();
    rsp_out_ready_i = 1'b1;
    auto_rsp = 1'b1;
    rsp_pct  = 100;
    rsp_update();
    repeat (5) step();
    check("rr_grant_count", grant_log.size(), 5);
    for (int k = 0; k < 5; k++) check("rr_grant_order", grant_log[k], exp_order[k]);
    rsp_out_ready_i = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rr_blocked_ready", rsp_in_ready_o, '0);
    check("rr_blocked_out_valid", rsp_out_valid_o, 1'b1);
    drain();

    // Orphan response sets the sticky error flag
    do_reset();
    rsp_out_ready_i = 1'b1;
    manual_rsp(3);
    repeat (4) step();
    @(negedge clk);
    check("err_sticky", err_o, 1'b1);
    check("err_idle", idle_o, 1'b1);
    do_reset();

    // Request and response on bank 0 in the same cycle: counter unchanged
    req_out_ready_i = '1;
    rsp_out_ready_i = 1'b1;
    send_req(32'h00);
    req_in_valid_i = 1'b0;
    step();
    set_req(32'h00);
    step();
    req_in_valid_i = 1'b0;
    manual_rsp(0);
    step();
    @(negedge clk);
    check("same_cycle_busy", idle_o, 1'b0);
    drain();

    // Randomized traffic, with reset asserted mid-burst
    auto_rsp = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!req_in_valid_i || req_in_fired) begin
        if ($urandom_range(99) < 60) set_req($urandom);
        else req_in_valid_i = 1'b0;
      end
      req_out_ready_i = NB'($urandom);
      rsp_out_ready_i = ($urandom_range(99) < 70);
      rsp_pct = 50;
      if (c == 1500) begin
        rst = 1'b1;
        #1;
        check("midrst_req_out_valid", req_out_valid_o, '0);
        check("midrst_rsp_out_valid", rsp_out_valid_o, 1'b0);
        check("midrst_rsp_in_ready", rsp_in_ready_o, '0);
        check("midrst_idle", idle_o, 1'b1);
        do_reset();
        auto_rsp = 1'b1;
      end
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
